alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Two-port round-robin arbiter that time-shares one ALU instance between two requesters, e.g. the execute stage and a branch/address helper. Each port has a valid/ready request channel carrying operands and an ALU select code, plus a valid/ready response channel. One operation is granted per cycle. The ALU result is registered into a per-port response slot, so each port has its own back-pressure.

## Interface
Parameters:
- RR_RESET, 0: port that wins the first simultaneous request after reset (0 = A, 1 = B).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- a_req_valid  input  1  port A has an operation.
- a_req_ready  output  1  port A operation accepted this cycle.
- a_src1, a_src2  input  32  port A operands.
- a_alusel  input  15  port A ALU select, using the `ADD/`SUB/`SLL/`SLT/`SLTU/`XOR/`SRL/`SRA/`OR/`AND encodings from rv32_define.v.
- a_resp_valid  output  1  port A result slot full.
- a_resp_ready  input  1  port A consumer takes the result.
- a_resp_data  output  32  port A result.
- b_*: same set as the a_* ports, for port B.

## Operation
- One internal ALU instance. Its operand and select inputs are muxed from the granted port.
- can_accept_X = !X_resp_valid | X_resp_ready. A slot being drained this cycle may be refilled in the same cycle.
- elig_X = X_req_valid & can_accept_X.
- Grant rules:
  - Both eligible: grant the port named by rr_ptr.
  - Only one eligible: grant that port.
  - Neither eligible: no grant.
- rr_ptr: 1-bit register. On any grant it loads the non-granted port. With no grant it holds.
- X_req_ready = grant_X. It is combinational from req_valid, the response-slot state and rr_ptr, and is never asserted for a non-eligible port.
- On the grant edge: X_resp_data <= ALU out; X_resp_valid <= 1.
- On an edge with X_resp_valid & X_resp_ready and no grant to X: X_resp_valid <= 0, X_resp_data holds.
- While X_resp_valid & !X_resp_ready: X_resp_data is stable.
- Select codes are not validated. A code matching no encoding yields result 0 and completes normally.
- Arithmetic is 32-bit wrap-around: ADD/SUB carry is discarded. Shift amount is src2[4:0]. SLT is signed, SLTU unsigned, and both return 0 or 1.
- Requests are never reordered or dropped once req_ready is seen. A port waiting while the other is granted is served no later than the next cycle in which it stays eligible.

## Timing
- Reset (rst_n low, asynchronous):
  - a/b_resp_valid = 0, a/b_resp_data = 0, rr_ptr = RR_RESET.
  - a/b_req_ready forced to 0 while rst_n is low.
- Reset release: normal operation from the first rising edge with rst_n high.
- Latency: request accepted on edge N → resp_valid high and resp_data valid immediately after edge N. The consumer may take it on edge N+1.
- Throughput: one grant per cycle in total. A single port with its consumer always ready sustains 1 op/cycle. Two continuously requesting ports alternate A, B, A, B…
- Reset mid-operation: pending results in both slots are discarded, rr_ptr returns to RR_RESET, and no response is ever issued for them.
- Requester contract: X_src1, X_src2 and X_alusel are held stable while X_req_valid is high and X_req_ready is low.

## Test plan
- Single op: A: ADD 5,7 with a_resp_ready=1.
  - Expect a_req_ready=1 in the same cycle, a_resp_valid=1 and a_resp_data=12 the next cycle, then a_resp_valid=0.
- Contention, RR_RESET=0: A: SUB 10,3 and B: SLL 1,4 both valid, both consumers ready.
  - Cycle 1: A granted, b_req_ready=0.
  - Cycle 2: B granted.
  - Responses: a_resp_data=7, b_resp_data=16. rr_ptr ends at 0.
- Back-pressure: a_resp_ready=0 with one A result pending, a new A request and a B request (XOR 0xFF,0x0F).
  - a_req_ready stays 0 and a_resp_data is held.
  - B is granted with b_resp_data=0xF0.
  - Raising a_resp_ready grants A in that same cycle.
- Arithmetic edges, each checked on its response:
  - SRA 0x80000000,4 → 0xF8000000.
  - SLT 0xFFFFFFFF,1 → 1.
  - SLTU 0xFFFFFFFF,1 → 0.
  - ADD 0xFFFFFFFF,1 → 0.
  - Undefined select → 0.
- Reset mid-operation: assert rst_n low asynchronously with both slots full.
  - Both resp_valid drop immediately, both req_ready are 0 during reset.
  - After release, a contended request is granted to port RR_RESET.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//
// Purpose: time-shares a single ALU between two requesters (A and B). Each
// cycle at most one request is granted, round-robin when both are eligible.
// The ALU result is captured in a per-port response slot so each port has
// independent back-pressure on its response channel.
//
// Parameters:
//   RR_RESET     - port preferred on the first simultaneous request after
//                  reset (0 = A, 1 = B).
//
// Ports:
//   clk          - clock, all state updates on the rising edge
//   rst_n        - asynchronous active-low reset
//   x_req_valid  - port X has an operation (X = a or b)
//   x_req_ready  - port X operation accepted this cycle (combinational)
//   x_src1/2     - port X operands (32 bit)
//   x_alusel     - port X one-hot ALU select (15 bit)
//   x_resp_valid - port X response slot full
//   x_resp_ready - port X consumer takes the response
//   x_resp_data  - port X result (32 bit)

module alu_share_arbiter #(
  parameter bit RR_RESET = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        a_req_valid,
  output logic        a_req_ready,
  input  logic [31:0] a_src1,
  input  logic [31:0] a_src2,
  input  logic [14:0] a_alusel,
  output logic        a_resp_valid,
  input  logic        a_resp_ready,
  output logic [31:0] a_resp_data,

  input  logic        b_req_valid,
  output logic        b_req_ready,
  input  logic [31:0] b_src1,
  input  logic [31:0] b_src2,
  input  logic [14:0] b_alusel,
  output logic        b_resp_valid,
  input  logic        b_resp_ready,
  output logic [31:0] b_resp_data
);

  // One-hot ALU select encodings shared with the requesters
  localparam logic [14:0] ALU_ADD  = 15'h0001;
  localparam logic [14:0] ALU_SUB  = 15'h0002;
  localparam logic [14:0] ALU_SLL  = 15'h0004;
  localparam logic [14:0] ALU_SLT  = 15'h0008;
  localparam logic [14:0] ALU_SLTU = 15'h0010;
  localparam logic [14:0] ALU_XOR  = 15'h0020;
  localparam logic [14:0] ALU_SRL  = 15'h0040;
  localparam logic [14:0] ALU_SRA  = 15'h0080;
  localparam logic [14:0] ALU_OR   = 15'h0100;
  localparam logic [14:0] ALU_AND  = 15'h0200;

  logic        rrPtr_q;
  logic        aRespValid_q, bRespValid_q;
  logic [31:0] aRespData_q, bRespData_q;

  logic        canAcceptA, canAcceptB;
  logic        eligA, eligB;
  logic        grantA, grantB;

  logic [31:0] aluSrc1, aluSrc2, aluOut;
  logic [14:0] aluSel;
  logic [4:0]  shamt;

  // A slot being drained this cycle can be refilled on the same edge
  assign canAcceptA = !aRespValid_q || a_resp_ready;
  assign canAcceptB = !bRespValid_q || b_resp_ready;
  assign eligA      = a_req_valid && canAcceptA;
  assign eligB      = b_req_valid && canAcceptB;

  // rrPtr_q names the port that wins a tie; a lone eligible port always wins
  assign grantA = eligA && (!eligB || (rrPtr_q == 1'b0));
  assign grantB = eligB && (!eligA || (rrPtr_q == 1'b1));

  // Ready is suppressed while reset is held so nothing looks accepted
  assign a_req_ready = grantA && rst_n;
  assign b_req_ready = grantB && rst_n;

  // Operand mux: B only drives the ALU when it holds the grant
  always_comb begin
    aluSrc1 = a_src1;
    aluSrc2 = a_src2;
    aluSel  = a_alusel;
    if (grantB) begin
      aluSrc1 = b_src1;
      aluSrc2 = b_src2;
      aluSel  = b_alusel;
    end
  end

  assign shamt = aluSrc2[4:0];

  // Shared ALU; any select that is not a known one-hot code yields zero
  always_comb begin
    aluOut = 32'd0;
    case (aluSel)
      ALU_ADD:  aluOut = aluSrc1 + aluSrc2;
      ALU_SUB:  aluOut = aluSrc1 - aluSrc2;
      ALU_SLL:  aluOut = aluSrc1 << shamt;
      ALU_SLT:  aluOut = {31'd0, $signed(aluSrc1) < $signed(aluSrc2)};
      ALU_SLTU: aluOut = {31'd0, aluSrc1 < aluSrc2};
      ALU_XOR:  aluOut = aluSrc1 ^ aluSrc2;
      ALU_SRL:  aluOut = aluSrc1 >> shamt;
      ALU_SRA:  aluOut = $unsigned($signed(aluSrc1) >>> shamt);
      ALU_OR:   aluOut = aluSrc1 | aluSrc2;
      ALU_AND:  aluOut = aluSrc1 & aluSrc2;
      default:  aluOut = 32'd0;
    endcase
  end

  // Round-robin pointer moves to the port that lost (or was idle) on a grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rrPtr_q <= RR_RESET;
    end else if (grantA) begin
      rrPtr_q <= 1'b1;
    end else if (grantB) begin
      rrPtr_q <= 1'b0;
    end
  end

  // Port A response slot: a grant fills it, a handshake without grant empties it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aRespValid_q <= 1'b0;
      aRespData_q  <= 32'd0;
    end else if (grantA) begin
      aRespValid_q <= 1'b1;
      aRespData_q  <= aluOut;
    end else if (aRespValid_q && a_resp_ready) begin
      aRespValid_q <= 1'b0;
    end
  end

  // Port B response slot, same behaviour as port A
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bRespValid_q <= 1'b0;
      bRespData_q  <= 32'd0;
    end else if (grantB) begin
      bRespValid_q <= 1'b1;
      bRespData_q  <= aluOut;
    end else if (bRespValid_q && b_resp_ready) begin
      bRespValid_q <= 1'b0;
    end
  end

  assign a_resp_valid = aRespValid_q;
  assign a_resp_data  = aRespData_q;
  assign b_resp_valid = bRespValid_q;
  assign b_resp_data  = bRespData_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter
//
// Purpose: self-checking bench for alu_share_arbiter. Directed scenarios
// cover single ops, contention, back-pressure, arithmetic corner cases and
// reset in mid-operation; a randomized phase follows. A behavioural model
// tracks each port's response slot and the tie-break preference and predicts
// grants and results.

module tb_alu_share_arbiter;

  localparam logic [14:0] ALU_ADD  = 15'h0001;
  localparam logic [14:0] ALU_SUB  = 15'h0002;
  localparam logic [14:0] ALU_SLL  = 15'h0004;
  localparam logic [14:0] ALU_SLT  = 15'h0008;
  localparam logic [14:0] ALU_SLTU = 15'h0010;
  localparam logic [14:0] ALU_XOR  = 15'h0020;
  localparam logic [14:0] ALU_SRL  = 15'h0040;
  localparam logic [14:0] ALU_SRA  = 15'h0080;
  localparam logic [14:0] ALU_OR   = 15'h0100;
  localparam logic [14:0] ALU_AND  = 15'h0200;
  localparam logic [14:0] ALU_BAD  = 15'h0003;

  logic        clk;
  logic        rst_n;
  logic        aReqValid, aReqReady, aRespValid, aRespReady;
  logic        bReqValid, bReqReady, bRespValid, bRespReady;
  logic [31:0] aSrc1, aSrc2, aRespData;
  logic [31:0] bSrc1, bSrc2, bRespData;
  logic [14:0] aAluSel, bAluSel;

  int checks;
  int failures;

  // Behavioural model state: slot contents and which port wins a tie
  logic        mValidA, mValidB;
  logic [31:0] mDataA, mDataB;
  int          mPreferred;
  logic        lastGrantA, lastGrantB;

  alu_share_arbiter #(.RR_RESET(1'b0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .a_req_valid  (aReqValid),
    .a_req_ready  (aReqReady),
    .a_src1       (aSrc1),
    .a_src2       (aSrc2),
    .a_alusel     (aAluSel),
    .a_resp_valid (aRespValid),
    .a_resp_ready (aRespReady),
    .a_resp_data  (aRespData),
    .b_req_valid  (bReqValid),
    .b_req_ready  (bReqReady),
    .b_src1       (bSrc1),
    .b_src2       (bSrc2),
    .b_alusel     (bAluSel),
    .b_resp_valid (bRespValid),
    .b_resp_ready (bRespReady),
    .b_resp_data  (bRespData)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Reference ALU written from the operation definitions
  function automatic logic [31:0] aluModel(input logic [14:0] sel,
                                           input logic [31:0] s1,
                                           input logic [31:0] s2);
    logic [4:0] sh;
    sh = s2[4:0];
    case (sel)
      ALU_ADD:  return s1 + s2;
      ALU_SUB:  return s1 + (~s2) + 32'd1;
      ALU_SLL:  return s1 << sh;
      ALU_SLT:  return (s1[31] != s2[31]) ? {31'd0, s1[31]} : {31'd0, s1 < s2};
      ALU_SLTU: return {31'd0, s1 < s2};
      ALU_XOR:  return s1 ^ s2;
      ALU_SRL:  return s1 >> sh;
      ALU_SRA:  return s1[31] ? ~((~s1) >> sh) : (s1 >> sh);
      ALU_OR:   return s1 | s2;
      ALU_AND:  return s1 & s2;
      default:  return 32'd0;
    endcase
  endfunction

  // Drive a full set of request inputs for both ports
  task automatic applyStimulus(input logic av, input logic [14:0] aop,
                               input logic [31:0] a1, input logic [31:0] a2,
                               input logic ardy,
                               input logic bv, input logic [14:0] bop,
                               input logic [31:0] b1, input logic [31:0] b2,
                               input logic brdy);
    aReqValid = av; aAluSel = aop; aSrc1 = a1; aSrc2 = a2; aRespReady = ardy;
    bReqValid = bv; bAluSel = bop; bSrc1 = b1; bSrc2 = b2; bRespReady = brdy;
  endtask

  task automatic modelReset();
    mValidA = 1'b0; mValidB = 1'b0;
    mDataA  = 32'd0; mDataB = 32'd0;
    mPreferred = 0;
  endtask

  // Run one clock cycle from a falling edge: predict and check grants, then
  // advance the model on the rising edge and check both response slots.
  // A granted request is retired so the next cycle starts with it idle.
  task automatic stepCycle();
    logic eA, eB, gA, gB;
    #2;
    eA = aReqValid && (!mValidA || aRespReady);
    eB = bReqValid && (!mValidB || bRespReady);
    if (eA && eB) begin
      gA = (mPreferred == 0);
      gB = (mPreferred == 1);
    end else begin
      gA = eA;
      gB = eB;
    end
    checkOutput("a_req_ready", {31'd0, aReqReady}, {31'd0, gA});
    checkOutput("b_req_ready", {31'd0, bReqReady}, {31'd0, gB});
    @(posedge clk);
    if (gA) begin
      mDataA = aluModel(aAluSel, aSrc1, aSrc2); mValidA = 1'b1;
    end else if (mValidA && aRespReady) begin
      mValidA = 1'b0;
    end
    if (gB) begin
      mDataB = aluModel(bAluSel, bSrc1, bSrc2); mValidB = 1'b1;
    end else if (mValidB && bRespReady) begin
      mValidB = 1'b0;
    end
    if (gA) mPreferred = 1;
    else if (gB) mPreferred = 0;
    lastGrantA = gA;
    lastGrantB = gB;
    @(negedge clk);
    checkOutput("a_resp_valid", {31'd0, aRespValid}, {31'd0, mValidA});
    checkOutput("b_resp_valid", {31'd0, bRespValid}, {31'd0, mValidB});
    if (mValidA) checkOutput("a_resp_data", aRespData, mDataA);
    if (mValidB) checkOutput("b_resp_data", bRespData, mDataB);
    if (gA) aReqValid = 1'b0;
    if (gB) bReqValid = 1'b0;
  endtask

  // Synchronous-looking reset pulse aligned to falling edges
  task automatic pulseReset();
    rst_n = 1'b0;
    modelReset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [14:0] randomOp();
    logic [14:0] ops [11];
    ops = '{ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
            ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_BAD};
    return ops[$urandom_range(10, 0)];
  endfunction

  function automatic logic [31:0] randomOperand();
    case ($urandom_range(4, 0))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return $urandom_range(40, 0);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    checks = 0;
    failures = 0;
    lastGrantA = 1'b0;
    lastGrantB = 1'b0;
    modelReset();
    rst_n = 1'b0;
    applyStimulus(1'b1, ALU_ADD, 32'd1, 32'd2, 1'b1,
                  1'b1, ALU_ADD, 32'd3, 32'd4, 1'b1);

    // Reset state with requests pending: nothing ready, slots empty
    @(negedge clk);
    #2;
    checkOutput("rst_a_req_ready", {31'd0, aReqReady}, 32'd0);
    checkOutput("rst_b_req_ready", {31'd0, bReqReady}, 32'd0);
    checkOutput("rst_a_resp_valid", {31'd0, aRespValid}, 32'd0);
    checkOutput("rst_b_resp_valid", {31'd0, bRespValid}, 32'd0);
    checkOutput("rst_a_resp_data", aRespData, 32'd0);
    checkOutput("rst_b_resp_data", bRespData, 32'd0);
    @(negedge clk);
    applyStimulus(1'b0, ALU_ADD, 32'd0, 32'd0, 1'b1,
                  1'b0, ALU_ADD, 32'd0, 32'd0, 1'b1);
    rst_n = 1'b1;

    // Single op on A
    applyStimulus(1'b1, ALU_ADD, 32'd5, 32'd7, 1'b1,
                  1'b0, ALU_ADD, 32'd0, 32'd0, 1'b1);
    stepCycle();
    checkOutput("single_grant", {31'd0, lastGrantA}, 32'd1);
    checkOutput("single_data", aRespData, 32'd12);
    stepCycle();
    checkOutput("single_drain", {31'd0, aRespValid}, 32'd0);

    // Contention straight after reset: A first, then B
    pulseReset();
    applyStimulus(1'b1, ALU_SUB, 32'd10, 32'd3, 1'b1,
                  1'b1, ALU_SLL, 32'd1, 32'd4, 1'b1);
    stepCycle();
    checkOutput("cont_b_held", {31'd0, bReqValid}, 32'd1);
    checkOutput("cont_a_data", aRespData, 32'd7);
    stepCycle();
    checkOutput("cont_b_data", bRespData, 32'd16);

    // Back-pressure on A while B proceeds
    applyStimulus(1'b1, ALU_OR, 32'h1234_0000, 32'h0000_5678, 1'b0,
                  1'b0, ALU_ADD, 32'd0, 32'd0, 1'b1);
    stepCycle();
    applyStimulus(1'b1, ALU_AND, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 1'b0,
                  1'b1, ALU_XOR, 32'h0000_00FF, 32'h0000_000F, 1'b1);
    stepCycle();
    checkOutput("bp_a_blocked", {31'd0, lastGrantA}, 32'd0);
    checkOutput("bp_a_held", aRespData, 32'h1234_5678);
    checkOutput("bp_b_data", bRespData, 32'h0000_00F0);
    aRespReady = 1'b1;
    stepCycle();
    checkOutput("bp_a_released", {31'd0, lastGrantA}, 32'd1);
    checkOutput("bp_a_new", aRespData, 32'h0F0F_0F0F);

    // Arithmetic corner cases on A
    applyStimulus(1'b1, ALU_SRA, 32'h8000_0000, 32'd4, 1'b1,
                  1'b0, ALU_ADD, 32'd0, 32'd0, 1'b1);
    stepCycle();
    checkOutput("sra_edge", aRespData, 32'hF800_0000);
    applyStimulus(1'b1, ALU_SLT, 32'hFFFF_FFFF, 32'd1, 1'b1,
                  1'b0, ALU_ADD, 32'd0, 32'd0, 1'b1);
    stepCycle();
    checkOutput("slt_edge", aRespData, 32'd1);
    applyStimulus(1'b1, ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 1'b1,
                  1'b0, ALU_ADD, 32'd0, 32'd0, 1'b1);
    stepCycle();
    checkOutput("sltu_edge", aRespData, 32'd0);
    applyStimulus(1'b1, ALU_ADD, 32'hFFFF_FFFF, 32'd1, 1'b1,
                  1'b0, ALU_ADD, 32'd0, 32'd0, 1'b1);
    stepCycle();
    checkOutput("add_wrap", aRespData, 32'd0);
    applyStimulus(1'b1, ALU_BAD, 32'h1234_5678, 32'd9, 1'b1,
                  1'b0, ALU_ADD, 32'd0, 32'd0, 1'b1);
    stepCycle();
    checkOutput("bad_sel", aRespData, 32'd0);

    // Randomized traffic; a pending request keeps its operands until granted
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!aReqValid && ($urandom_range(3, 0) != 0)) begin
        aReqValid = 1'b1; aAluSel = randomOp();
        aSrc1 = randomOperand(); aSrc2 = randomOperand();
      end
      if (!bReqValid && ($urandom_range(3, 0) != 0)) begin
        bReqValid = 1'b1; bAluSel = randomOp();
        bSrc1 = randomOperand(); bSrc2 = randomOperand();
      end
      aRespReady = ($urandom_range(3, 0) != 0);
      bRespReady = ($urandom_range(3, 0) != 0);
      stepCycle();
    end

    // Fill both slots, then reset asynchronously in the middle of a cycle
    applyStimulus(1'b1, ALU_ADD, 32'd1, 32'd1, 1'b0,
                  1'b1, ALU_ADD, 32'd2, 32'd2, 1'b0);
    stepCycle();
    stepCycle();
    stepCycle();
    checkOutput("full_a", {31'd0, aRespValid}, 32'd1);
    checkOutput("full_b", {31'd0, bRespValid}, 32'd1);
    applyStimulus(1'b1, ALU_ADD, 32'd3, 32'd3, 1'b1,
                  1'b1, ALU_ADD, 32'd4, 32'd4, 1'b1);
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("midrst_a_valid", {31'd0, aRespValid}, 32'd0);
    checkOutput("midrst_b_valid", {31'd0, bRespValid}, 32'd0);
    checkOutput("midrst_a_ready", {31'd0, aReqReady}, 32'd0);
    checkOutput("midrst_b_ready", {31'd0, bReqReady}, 32'd0);
    @(negedge clk);
    checkOutput("midrst_a_ready2", {31'd0, aReqReady}, 32'd0);
    rst_n = 1'b1;
    applyStimulus(1'b1, ALU_SUB, 32'd9, 32'd4, 1'b1,
                  1'b1, ALU_XOR, 32'd6, 32'd3, 1'b1);
    stepCycle();
    checkOutput("postrst_grant_a", {31'd0, lastGrantA}, 32'd1);
    checkOutput("postrst_grant_b", {31'd0, lastGrantB}, 32'd0);
    checkOutput("postrst_a_data", aRespData, 32'd5);
    stepCycle();
    checkOutput("postrst_b_data", bRespData, 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
